// File: rtl/seq_div_restoring_pkg.sv
// Shared ALU definitions: divider FSM state encoding and default datapath width.
package seq_div_restoring_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_restoring_sub_step.sv
// One restoring-division step: trial subtract T - {0,D} as T + ~{0,D} + 1, then restore or keep.
module div_sub_step #(
  parameter int unsigned W = 4
) (
  input  logic [W:0]   t,
  input  logic [W-1:0] d,
  output logic [W:0]   next_r,
  output logic         q_bit
);

  logic [W+1:0] sum;

  // Carry-out of the (W+1)-bit add is the no-borrow flag.
  assign sum    = {1'b0, t} + {1'b0, ~{1'b0, d}} + (W+2)'(1);
  assign q_bit  = sum[W+1];
  assign next_r = q_bit ? sum[W:0] : t;

endmodule

// File: rtl/seq_div_restoring.sv
// Multi-cycle unsigned restoring divider with start/done handshake and divide-by-zero flag.
module seq_div_restoring
  import seq_div_restoring_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic             dz_reg;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   next_r;
  logic             q_bit;
  logic             r_msb_unused;

  // Top partial-remainder bit is shifted out each step; it never feeds T.
  assign r_msb_unused = r_reg[WIDTH];
  assign t            = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  div_sub_step #(.W(WIDTH)) u_step (
    .t      (t),
    .d      (d_reg),
    .next_r (next_r),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      dz_reg      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            d_reg  <= divisor;
            q_reg  <= dividend;
            r_reg  <= '0;
            dz_reg <= (divisor == '0);
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_reg <= next_r;
          q_reg <= {q_reg[WIDTH-2:0], q_bit};
          cnt   <= cnt - CNT_W'(1);
          // Final step: publish results straight from the step outputs.
          if (cnt == CNT_W'(1)) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {q_reg[WIDTH-2:0], q_bit};
            remainder   <= next_r[WIDTH-1:0];
            div_by_zero <= dz_reg;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_restoring.sv
// Directed and exhaustive self-checking bench for seq_div_restoring at WIDTH=4.
module tb_seq_div_restoring;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div_restoring #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert start with operands for exactly one rising edge (the accept edge).
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    pulse_start(4'd13, 4'd3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL basic_run_edge%0d: busy/done=%b expected 10", i, {busy, done});
      end
    end
    tick();
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {2'b01, 4'd4, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: busy=%0b done=%0b q=%0d r=%0d dz=%0b expected 0 1 4 1 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    tick();
    n_checks++;
    if ({busy, done, quotient, remainder} !== {2'b00, 4'd4, 4'd1}) begin
      n_fail++;
      $display("FAIL basic_after: busy=%0b done=%0b q=%0d r=%0d expected 0 0 4 1",
               busy, done, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(4'd15, 4'd1);
    tick(); tick(); tick();
    tick();
    n_checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd15, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: done=%0b q=%0d r=%0d dz=%0b expected 1 15 0 0",
               done, quotient, remainder, div_by_zero);
    end
    pulse_start(4'd2, 4'd9);
    n_checks++;
    if ({busy, done, quotient, remainder} !== {2'b10, 4'd15, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%0b done=%0b q=%0d r=%0d expected 1 0 15 0 (held)",
               busy, done, quotient, remainder);
    end
    tick(); tick(); tick();
    tick();
    n_checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd0, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: done=%0b q=%0d r=%0d dz=%0b expected 1 0 2 0",
               done, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_div_by_zero();
    pulse_start(4'd7, 4'd0);
    tick(); tick(); tick();
    tick();
    n_checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd15, 4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL dz_result: done=%0b q=%0d r=%0d dz=%0b expected 1 15 7 1",
               done, quotient, remainder, div_by_zero);
    end
    tick();
    n_checks++;
    if ({done, div_by_zero} !== 2'b01) begin
      n_fail++;
      $display("FAIL dz_pulse: done=%0b dz=%0b expected 0 1", done, div_by_zero);
    end
    pulse_start(4'd8, 4'd2);
    tick(); tick(); tick();
    tick();
    n_checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd4, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL dz_clear: done=%0b q=%0d r=%0d dz=%0b expected 1 4 0 0",
               done, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones;
    pulse_start(4'd9, 4'd4);
    tick();
    pulse_start(4'd15, 4'd5);
    tick();
    tick();
    n_checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd2, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL ignored_result: done=%0b q=%0d r=%0d dz=%0b expected 1 2 1 0",
               done, quotient, remainder, div_by_zero);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL ignored_no_second: busy/done cycles=%0d expected 0", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    pulse_start(4'd14, 4'd3);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: busy/done cycles=%0d expected 0", dones);
    end
    pulse_start(4'd14, 4'd3);
    tick(); tick(); tick();
    tick();
    n_checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd4, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_retry: done=%0b q=%0d r=%0d dz=%0b expected 1 4 2 0",
               done, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] eq, er;
    logic         edz, early;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'd15; er = W'(a); edz = 1'b1;
        end else begin
          eq = W'(a / b); er = W'(a % b); edz = 1'b0;
        end
        pulse_start(W'(a), W'(b));
        early = 1'b0;
        for (int i = 1; i <= 3; i++) begin
          tick();
          early = early | done | ~busy;
        end
        tick();
        n_checks++;
        if ({early, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, eq, er, edz}) begin
          n_fail++;
          $display("FAIL sweep_%0d_%0d: early=%0b done=%0b q=%0d r=%0d dz=%0b expected 0 1 %0d %0d %0b",
                   a, b, early, done, quotient, remainder, div_by_zero, eq, er, edz);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_start_ignored();
    test_reset_abort();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
